// File: rtl/vga_pkg.sv
// Shared types, widths and helpers for the VGA scan-out engine.
// Timing bounds are derived once here and handed to the sub-blocks.
package vga_pkg;

    localparam int DISPLAY_CDEPTH    = 4;
    localparam int MM_CSR_ADDR_WIDTH = 4;
    localparam int MM_CSR_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        PIX_RGB565 = 2'd0,
        PIX_RGB444 = 2'd1,
        PIX_GREY8  = 2'd2
    } pix_fmt_e;

    typedef enum logic {
        CSR_IDLE,
        CSR_WRITE
    } csr_state_e;

    typedef struct packed {
        logic [DISPLAY_CDEPTH-1:0] r;
        logic [DISPLAY_CDEPTH-1:0] g;
        logic [DISPLAY_CDEPTH-1:0] b;
    } rgb_t;

    typedef struct packed {
        int h_active;
        int h_total;
        int hs_start;
        int hs_end;
        int v_active;
        int v_total;
        int vs_start;
        int vs_end;
    } vga_timing_t;

    function automatic vga_timing_t make_timing(
        int ha, int hfp, int hs, int hbp,
        int va, int vfp, int vs, int vbp
    );
        vga_timing_t t;
        t.h_active = ha;
        t.h_total  = ha + hfp + hs + hbp;
        t.hs_start = ha + hfp;
        t.hs_end   = ha + hfp + hs;
        t.v_active = va;
        t.v_total  = va + vfp + vs + vbp;
        t.vs_start = va + vfp;
        t.vs_end   = va + vfp + vs;
        return t;
    endfunction

    // Left-align a w-bit field in 8 bits, then keep the top D bits;
    // narrow fields come out zero-padded on the right.
    function automatic logic [DISPLAY_CDEPTH-1:0] field(
        logic [15:0] d, int lsb, int w
    );
        logic [31:0] t;
        t = (32'(d) >> lsb) << (8 - w);
        return t[7 -: DISPLAY_CDEPTH];
    endfunction

    function automatic rgb_t unpack(pix_fmt_e fmt, logic [15:0] d);
        rgb_t p;
        p = '0;
        case (fmt)
            PIX_RGB565: begin
                p.r = field(d, 11, 5);
                p.g = field(d, 5, 6);
                p.b = field(d, 0, 5);
            end
            PIX_RGB444: begin
                p.r = field(d, 8, 4);
                p.g = field(d, 4, 4);
                p.b = field(d, 0, 4);
            end
            PIX_GREY8: begin
                p.r = field(d, 0, 8);
                p.g = field(d, 0, 8);
                p.b = field(d, 0, 8);
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame stream sink and DMA restart CSR master bundled together.
// master is the scan-out side, slave is the system side.
interface vga_scanout_if
    import vga_pkg::*;
#(
    parameter int ST_DATA_WIDTH = 16
);

    logic                         st_ready;
    logic [ST_DATA_WIDTH-1:0]     st_data;
    logic                         st_startofpacket;
    logic                         st_endofpacket;
    logic                         st_valid;

    logic                         mm_csr_write;
    logic [MM_CSR_ADDR_WIDTH-1:0] mm_csr_address;
    logic [MM_CSR_DATA_WIDTH-1:0] mm_csr_writedata;
    logic                         mm_csr_waitrequest;

    modport master (
        output st_ready,
        input  st_data,
        input  st_startofpacket,
        input  st_endofpacket,
        input  st_valid,
        output mm_csr_write,
        output mm_csr_address,
        output mm_csr_writedata,
        input  mm_csr_waitrequest
    );

    modport slave (
        input  st_ready,
        output st_data,
        output st_startofpacket,
        output st_endofpacket,
        output st_valid,
        input  mm_csr_write,
        input  mm_csr_address,
        input  mm_csr_writedata,
        output mm_csr_waitrequest
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with active, sync-window and frame strobes.
// Counters start on the first blanking line so reset lands on a restart point.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_timing_t TIM = make_timing(640, 16, 96, 48, 480, 10, 2, 33)
) (
    input  logic clk,
    input  logic reset,
    output logic active,
    output logic hs_win,
    output logic vs_win,
    output logic restart,
    output logic first_pix,
    output logic last_pix
);

    localparam int HW = $clog2(TIM.h_total);
    localparam int VW = $clog2(TIM.v_total);

    localparam logic [31:0] H_ACT = 32'(TIM.h_active);
    localparam logic [31:0] H_END = 32'(TIM.h_total - 1);
    localparam logic [31:0] HS_B  = 32'(TIM.hs_start);
    localparam logic [31:0] HS_E  = 32'(TIM.hs_end);
    localparam logic [31:0] V_ACT = 32'(TIM.v_active);
    localparam logic [31:0] V_END = 32'(TIM.v_total - 1);
    localparam logic [31:0] VS_B  = 32'(TIM.vs_start);
    localparam logic [31:0] VS_E  = 32'(TIM.vs_end);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [31:0]   hx;
    logic [31:0]   vx;

    assign hx = 32'(h);
    assign vx = 32'(v);

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= VW'(TIM.v_active);
        end else if (hx == H_END) begin
            h <= '0;
            v <= (vx == V_END) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign active    = (hx < H_ACT) && (vx < V_ACT);
    assign hs_win    = (hx >= HS_B) && (hx < HS_E);
    assign vs_win    = (vx >= VS_B) && (vx < VS_E);
    assign restart   = (hx == 32'd0) && (vx == V_ACT);
    assign first_pix = (hx == 32'd0) && (vx == 32'd0);
    assign last_pix  = (hx == H_ACT - 32'd1) && (vx == V_ACT - 32'd1);

endmodule

// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out: sync generation, stream pixel fetch,
// per-frame DMA restart write and underflow/framing status.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit HS_POL        = 1'b0,
    parameter bit VS_POL        = 1'b0,
    parameter int ST_DATA_WIDTH = 16,
    parameter int PIX_FMT       = 0,
    parameter int RESTART_ADDR  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    vga_scanout_if.master             bus,
    output logic                      vga_hs_out,
    output logic                      vga_vs_out,
    output logic [DISPLAY_CDEPTH-1:0] vga_r,
    output logic [DISPLAY_CDEPTH-1:0] vga_g,
    output logic [DISPLAY_CDEPTH-1:0] vga_b,
    output logic                      underflow,
    output logic                      sop_err
);

    localparam vga_timing_t TIM = make_timing(
        H_ACTIVE, H_FP, H_SYNC, H_BP,
        V_ACTIVE, V_FP, V_SYNC, V_BP
    );
    localparam pix_fmt_e FMT = pix_fmt_e'(PIX_FMT);

    logic active;
    logic hs_win;
    logic vs_win;
    logic restart;
    logic first_pix;
    logic last_pix;

    vga_timing_gen #(
        .TIM (TIM)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .hs_win    (hs_win),
        .vs_win    (vs_win),
        .restart   (restart),
        .first_pix (first_pix),
        .last_pix  (last_pix)
    );

    logic                     frame_en;
    logic                     req;
    logic                     accept;
    logic [ST_DATA_WIDTH-1:0] pix_word;
    rgb_t                     pix;
    logic                     u_acc;
    logic                     s_acc;

    assign req          = active & frame_en;
    assign accept       = req & bus.st_valid;
    assign bus.st_ready = req;
    assign pix_word     = bus.st_data;
    assign pix          = unpack(FMT, pix_word[15:0]);

    // Colour and syncs share one register stage to stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_hs_out            <= !HS_POL;
            vga_vs_out            <= !VS_POL;
        end else begin
            {vga_r, vga_g, vga_b} <= accept ? pix : '0;
            vga_hs_out            <= hs_win ? HS_POL : !HS_POL;
            vga_vs_out            <= vs_win ? VS_POL : !VS_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_en  <= 1'b0;
            u_acc     <= 1'b0;
            s_acc     <= 1'b0;
            underflow <= 1'b0;
            sop_err   <= 1'b0;
        end else if (restart) begin
            frame_en  <= enable;
            underflow <= u_acc;
            sop_err   <= s_acc;
            u_acc     <= 1'b0;
            s_acc     <= 1'b0;
        end else begin
            if (req && !bus.st_valid)
                u_acc <= 1'b1;
            if (accept && first_pix && !bus.st_startofpacket)
                s_acc <= 1'b1;
            if (accept && bus.st_endofpacket && !last_pix)
                s_acc <= 1'b1;
        end
    end

    csr_state_e state;
    logic       csr_write;

    // Restarts seen while a write is still stalled are not queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CSR_IDLE;
            csr_write <= 1'b0;
        end else begin
            case (state)
                CSR_IDLE: begin
                    if (restart && enable) begin
                        state     <= CSR_WRITE;
                        csr_write <= 1'b1;
                    end
                end
                CSR_WRITE: begin
                    if (!bus.mm_csr_waitrequest) begin
                        state     <= CSR_IDLE;
                        csr_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= CSR_IDLE;
                    csr_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mm_csr_write     = csr_write;
    assign bus.mm_csr_address   = MM_CSR_ADDR_WIDTH'(RESTART_ADDR);
    assign bus.mm_csr_writedata = MM_CSR_DATA_WIDTH'(1);

endmodule
